// File: rtl/mem_scan_pkg.sv
// Shared definitions for the memory scan controller.
//   - default geometry (DEPTH/WIDTH), fixed address width, starvation limit
//   - scan FSM state encoding
//   - read-port request bundle used between the controller and its store
package mem_scan_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int WIDTH_DEF  = 3;
    localparam int AW         = 3;
    localparam int STARVE_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // One shared read port; 'scan' steers the result to the scan holding
    // register instead of the random-read register.
    typedef struct packed {
        logic          en;
        logic          scan;
        logic [AW-1:0] addr;
    } rd_port_t;

endpackage

// File: rtl/mem_scan_store.sv
// Storage array for mem_scan_ctrl.
//   clk, rst        : clock, async active-high reset (clears array and outputs)
//   wr_en/addr/data : write port, takes effect on every enabled edge
//   rd              : single read request (enable, destination, address)
//   scan_q          : registered read result for the scan engine
//   rand_q          : registered read result for the random-read port
// A read and a write to the same entry on one edge return the old value.
module mem_scan_store
    import mem_scan_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  rd_port_t         rd,
    output logic [WIDTH-1:0] scan_q,
    output logic [WIDTH-1:0] rand_q
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            scan_q <= '0;
            rand_q <= '0;
        end else begin
            if (wr_en && int'(wr_addr) < DEPTH) mem[wr_addr] <= wr_data;
            // Each holding register only moves when its own client reads,
            // so a presented scan entry survives random reads and vice versa.
            if (rd.en) begin
                if (rd.scan) scan_q <= mem[rd.addr];
                else         rand_q <= mem[rd.addr];
            end
        end
    end

endmodule

// File: rtl/mem_scan_ctrl.sv
// Memory scan controller: a small array that can be dumped entry by entry
// over a valid/ready stream while also serving random single reads.
//   clk, rst                   : clock, async active-high reset
//   wr_en, wr_addr, wr_data    : write port (always active)
//   scan_start                 : begin a dump of entries 0..DEPTH-1 (IDLE only)
//   scan_busy                  : FSM not idle
//   out_valid/ready/addr/data  : scan stream
//   scan_done                  : one-cycle pulse after the last entry is taken
//   rd_req, rd_addr            : random read request (held until acked)
//   rd_ack, rd_data            : random read response, data held between acks
module mem_scan_ctrl
    import mem_scan_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEF,
    parameter int WIDTH        = WIDTH_DEF,
    parameter int STARVE_LIMIT = STARVE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             scan_start,
    output logic             scan_busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_addr,
    output logic [WIDTH-1:0] out_data,
    output logic             scan_done,
    input  logic             rd_req,
    input  logic [AW-1:0]    rd_addr,
    output logic             rd_ack,
    output logic [WIDTH-1:0] rd_data
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    scan_state_t   state;
    logic [AW-1:0] ptr;
    logic [SW-1:0] starve_cnt;
    logic          in_fetch, scan_gnt, rd_gnt;
    rd_port_t      rd;

    // Random reads win by default; once they have starved the scan
    // STARVE_LIMIT times in a row, the waiting scan takes the port.
    assign in_fetch = (state == FETCH);
    assign scan_gnt = in_fetch && (!rd_req || starve_cnt == SLIM);
    assign rd_gnt   = rd_req && !scan_gnt;

    always_comb begin
        rd      = '0;
        rd.en   = scan_gnt | rd_gnt;
        rd.scan = scan_gnt;
        rd.addr = scan_gnt ? ptr : rd_addr;
    end

    mem_scan_store #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd      (rd),
        .scan_q  (out_data),
        .rand_q  (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            starve_cnt <= '0;
            out_addr   <= '0;
            out_valid  <= 1'b0;
            scan_done  <= 1'b0;
            scan_busy  <= 1'b0;
            rd_ack     <= 1'b0;
        end else begin
            rd_ack <= rd_gnt;

            // Starvation only accrues while the scan is actually waiting.
            if (scan_gnt)
                starve_cnt <= '0;
            else if (in_fetch && rd_gnt)
                starve_cnt <= starve_cnt + SW'(1);

            case (state)
                IDLE: begin
                    if (scan_start) begin
                        ptr       <= '0;
                        scan_busy <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (scan_gnt) begin
                        out_addr  <= ptr;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (ptr == LAST) begin
                            scan_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            ptr   <= ptr + AW'(1);
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    scan_done <= 1'b0;
                    scan_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
